// File: rtl/sumador_pkg.sv
// Shared types and default geometry for the segmented carry-lookahead adder.
package sumador_pkg;

    typedef enum logic {
        SUMA  = 1'b0,
        RESTA = 1'b1
    } modo_e;

    localparam int N_DEF      = 32;
    localparam int BLOQUE_DEF = 4;
    localparam int ETAPAS_DEF = 2;

endpackage

// File: rtl/cla_bloque.sv
// One BLOQUE-bit lookahead group: sum bits plus group generate/propagate, purely combinational.
module cla_bloque #(
    parameter int BLOQUE = 4
) (
    input  logic [BLOQUE-1:0] i_a,
    input  logic [BLOQUE-1:0] i_b,
    input  logic              i_c,
    output logic [BLOQUE-1:0] o_s,
    output logic              o_g,
    output logic              o_p
);

    logic [BLOQUE-1:0] w_g;
    logic [BLOQUE-1:0] w_p;
    logic [BLOQUE-1:0] w_c;

    // Carry into bit n as a flat sum of products: g[m] & p[m+1..n-1], plus c & p[0..n-1].
    function automatic logic acarreo(input logic [BLOQUE-1:0] g, input logic [BLOQUE-1:0] p,
                                     input logic c, input int n);
        logic suma;
        logic prod;
        suma = 1'b0;
        prod = 1'b1;
        for (int m = BLOQUE - 1; m >= 0; m--) begin
            if (m < n) begin
                suma = suma | (g[m] & prod);
                prod = prod & p[m];
            end
        end
        return suma | (prod & c);
    endfunction

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_c    = '0;
        w_c[0] = i_c;
        for (int i = 1; i < BLOQUE; i++) begin
            w_c[i] = acarreo(w_g, w_p, i_c, i);
        end
    end

    assign o_s = w_p ^ w_c;
    assign o_g = acarreo(w_g, w_p, 1'b0, BLOQUE);
    assign o_p = &w_p;

endmodule

// File: rtl/sumador_cla_segmentado.sv
// Pipelined CLA add/sub, one N/ETAPAS segment per stage, latency ETAPAS cycles; whole pipe stalls
// when the output is held (avance = !ValidSalida | ListoSalida). Flags exist only with SUMADOR_BANDERAS_EN.
module sumador_cla_segmentado
    import sumador_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int BLOQUE = BLOQUE_DEF,
    parameter int ETAPAS = ETAPAS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] Operando1,
    input  logic [N-1:0] Operando2,
    input  logic         CarryIn,
    input  logic         Resta,
    input  logic         ValidEntrada,
    output logic         ListoEntrada,
    output logic [N-1:0] Resultado,
    output logic         CarryOut,
    output logic         Desborde,
    output logic         Cero,
    output logic         ValidSalida,
    input  logic         ListoSalida
);

    localparam int SEG    = N / ETAPAS;
    localparam int GRUPOS = SEG / BLOQUE;
    localparam int ULT    = ETAPAS - 1;

    if (ETAPAS < 1 || BLOQUE < 1 || (N % (ETAPAS * BLOQUE)) != 0) begin : g_param_err
        $error("sumador_cla_segmentado: N must be a multiple of ETAPAS*BLOQUE, ETAPAS >= 1");
    end

    logic         w_avance;
    modo_e        w_modo;
    logic [N-1:0] w_b_ef;
    logic         w_c_ef;

    assign w_modo   = modo_e'(Resta);
    assign w_b_ef   = (w_modo == RESTA) ? ~Operando2 : Operando2;
    assign w_c_ef   = (w_modo == RESTA) ? 1'b1 : CarryIn;
    assign w_avance = !ValidSalida || ListoSalida;

    for (genvar k = 0; k < ETAPAS; k++) begin : g_etapa
        localparam int ANCHO_OP  = N - k * SEG;
        localparam int ANCHO_RES = (k + 1) * SEG;

        // Operands still to be added: segment k sits in the low SEG bits.
        logic [ANCHO_OP-1:0]  w_a;
        logic [ANCHO_OP-1:0]  w_b;
        logic                 w_c;
        logic                 w_v;
        logic [SEG-1:0]       w_seg;
        logic [ANCHO_RES-1:0] w_res;
        logic [GRUPOS:0]      w_cg;
        logic                 r_v;
        logic                 r_c;
        logic [ANCHO_RES-1:0] r_s;

        if (k == 0) begin : g_ent
            assign w_a   = Operando1;
            assign w_b   = w_b_ef;
            assign w_c   = w_c_ef;
            assign w_v   = ValidEntrada;
            assign w_res = w_seg;
        end else begin : g_int
            assign w_a   = g_etapa[k-1].g_skew.r_a;
            assign w_b   = g_etapa[k-1].g_skew.r_b;
            assign w_c   = g_etapa[k-1].r_c;
            assign w_v   = g_etapa[k-1].r_v;
            assign w_res = {w_seg, g_etapa[k-1].r_s};
        end

        assign w_cg[0] = w_c;
        for (genvar j = 0; j < GRUPOS; j++) begin : g_grupo
            logic w_g;
            logic w_p;
            cla_bloque #(.BLOQUE(BLOQUE)) u_cla (
                .i_a (w_a[j*BLOQUE +: BLOQUE]),
                .i_b (w_b[j*BLOQUE +: BLOQUE]),
                .i_c (w_cg[j]),
                .o_s (w_seg[j*BLOQUE +: BLOQUE]),
                .o_g (w_g),
                .o_p (w_p)
            );
            assign w_cg[j+1] = w_g | (w_p & w_cg[j]);
        end

        // Data only loads with a valid operation so outputs hold across bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_avance) begin
                r_v <= w_v;
                if (w_v) begin
                    r_c <= w_cg[GRUPOS];
                    r_s <= w_res;
                end
            end
        end

        if (k < ULT) begin : g_skew
            logic [ANCHO_OP-SEG-1:0] r_a;
            logic [ANCHO_OP-SEG-1:0] r_b;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_avance && w_v) begin
                    r_a <= w_a[ANCHO_OP-1:SEG];
                    r_b <= w_b[ANCHO_OP-1:SEG];
                end
            end
        end
    end

    assign ListoEntrada = w_avance;
    assign ValidSalida  = g_etapa[ULT].r_v;
    assign Resultado    = g_etapa[ULT].r_s;
    assign CarryOut     = g_etapa[ULT].r_c;

`ifdef SUMADOR_BANDERAS_EN
    logic w_desborde;
    logic w_cero;
    logic r_desborde;
    logic r_cero;

    // Last stage sees the top segment, so all three sign bits are available here.
    assign w_desborde = (g_etapa[ULT].w_a[SEG-1] == g_etapa[ULT].w_b[SEG-1]) &&
                        (g_etapa[ULT].w_res[N-1] != g_etapa[ULT].w_a[SEG-1]);
    assign w_cero     = (g_etapa[ULT].w_res == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_desborde <= 1'b0;
            r_cero     <= 1'b0;
        end else if (w_avance && g_etapa[ULT].w_v) begin
            r_desborde <= w_desborde;
            r_cero     <= w_cero;
        end
    end

    assign Desborde = r_desborde;
    assign Cero     = r_cero;
`else
    assign Desborde = 1'b0;
    assign Cero     = 1'b0;
`endif

endmodule

// File: tb/tb_sumador_cla_segmentado.sv
// Bench for sumador_cla_segmentado at N=8, BLOQUE=4, ETAPAS=2: directed cases plus a random stream
// checked against an integer-arithmetic model through an in-order expectation queue.
module tb_sumador_cla_segmentado;

`ifdef SUMADOR_BANDERAS_EN
    localparam bit BANDERAS = 1'b1;
`else
    localparam bit BANDERAS = 1'b0;
`endif

    typedef struct {
        logic [7:0] res;
        logic       co;
        logic       ov;
        logic       z;
    } esperado_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] Operando1 = '0;
    logic [7:0] Operando2 = '0;
    logic       CarryIn = 1'b0;
    logic       Resta = 1'b0;
    logic       ValidEntrada = 1'b0;
    logic       ListoEntrada;
    logic [7:0] Resultado;
    logic       CarryOut;
    logic       Desborde;
    logic       Cero;
    logic       ValidSalida;
    logic       ListoSalida = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_acept = 0;
    esperado_t cola[$];

    logic       prev_rst = 1'b1;
    logic       prev_vs  = 1'b0;
    logic       prev_ls  = 1'b0;
    logic [7:0] prev_res = '0;

    sumador_cla_segmentado #(.N(8), .BLOQUE(4), .ETAPAS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .Operando1    (Operando1),
        .Operando2    (Operando2),
        .CarryIn      (CarryIn),
        .Resta        (Resta),
        .ValidEntrada (ValidEntrada),
        .ListoEntrada (ListoEntrada),
        .Resultado    (Resultado),
        .CarryOut     (CarryOut),
        .Desborde     (Desborde),
        .Cero         (Cero),
        .ValidSalida  (ValidSalida),
        .ListoSalida  (ListoSalida)
    );

    always #5 clk = ~clk;

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: observado=0x%0h esperado=0x%0h", tag, obs, esp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic esperado_t modelo(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic resta);
        esperado_t e;
        int ua, ub, uc, total, sa, sb, ssum;
        ua    = int'(a);
        ub    = resta ? (255 - int'(b)) : int'(b);
        uc    = resta ? 1 : int'(cin);
        total = ua + ub + uc;
        sa    = (ua >= 128) ? ua - 256 : ua;
        sb    = resta ? -((int'(b) >= 128) ? int'(b) - 256 : int'(b)) : ((ub >= 128) ? ub - 256 : ub);
        ssum  = resta ? sa + sb : sa + sb + uc;
        e.res = 8'(total % 256);
        e.co  = (total >= 256);
        e.ov  = BANDERAS && (ssum > 127 || ssum < -128);
        e.z   = BANDERAS && ((total % 256) == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        esperado_t e;
        if (rst) begin
            cola.delete();
        end else begin
            verificar("listo_entrada", ListoEntrada, !ValidSalida || ListoSalida);
            if (ValidSalida && ListoSalida) begin
                if (cola.size() == 0) begin
                    verificar("salida_espuria", 1, 0);
                end else begin
                    e = cola.pop_front();
                    verificar("res", Resultado, e.res);
                    verificar("carry", CarryOut, e.co);
                    verificar("desborde", Desborde, e.ov);
                    verificar("cero", Cero, e.z);
                end
            end
            if (ValidEntrada && ListoEntrada) begin
                cola.push_back(modelo(Operando1, Operando2, CarryIn, Resta));
                n_acept++;
            end
            if (!prev_rst && ((prev_vs && !prev_ls) || (!prev_vs && !ValidSalida)))
                verificar("retencion", Resultado, prev_res);
            if (!prev_rst && prev_vs && !prev_ls)
                verificar("retencion_valid", ValidSalida, 1);
        end
        prev_rst = rst;
        prev_vs  = ValidSalida;
        prev_ls  = ListoSalida;
        prev_res = Resultado;
    end

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic operar(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic resta);
        Operando1    = a;
        Operando2    = b;
        CarryIn      = cin;
        Resta        = resta;
        ValidEntrada = 1'b1;
    endtask

    initial begin
        int ciclos;
        rst = 1'b1;
        ciclo();
        ciclo();
        rst = 1'b0;
        verificar("reset_valid", ValidSalida, 0);
        verificar("reset_res", Resultado, 0);
        verificar("reset_carry", CarryOut, 0);
        verificar("reset_desborde", Desborde, 0);
        verificar("reset_cero", Cero, 0);
        verificar("reset_listo", ListoEntrada, 1);

        // 0xFF + 0x80: latency and signed overflow
        operar(8'hFF, 8'h80, 1'b0, 1'b0);
        ciclo();
        ValidEntrada = 1'b0;
        verificar("lat_1ciclo_valid", ValidSalida, 0);
        ciclo();
        verificar("lat_2ciclos_valid", ValidSalida, 1);
        verificar("ff80_res", Resultado, 8'h7F);
        verificar("ff80_carry", CarryOut, 1);
        verificar("ff80_desborde", Desborde, BANDERAS);
        verificar("ff80_cero", Cero, 0);

        // 0x80 + 0xFF + 1, then 0x80 - 0x01 back to back
        operar(8'h80, 8'hFF, 1'b1, 1'b0);
        ciclo();
        operar(8'h80, 8'h01, 1'b0, 1'b1);
        ciclo();
        ValidEntrada = 1'b0;
        verificar("80ff_res", Resultado, 8'h80);
        verificar("80ff_carry", CarryOut, 1);
        verificar("80ff_desborde", Desborde, 0);
        ciclo();
        verificar("resta_80_01_res", Resultado, 8'h7F);
        verificar("resta_80_01_carry", CarryOut, 1);
        verificar("resta_80_01_desborde", Desborde, BANDERAS);

        // 0x05 - 0x05 with CarryIn=1 (ignored)
        operar(8'h05, 8'h05, 1'b1, 1'b1);
        ciclo();
        ValidEntrada = 1'b0;
        ciclo();
        verificar("resta_cero_res", Resultado, 8'h00);
        verificar("resta_cero_cero", Cero, BANDERAS);
        verificar("resta_cero_carry", CarryOut, 1);

        // Stream with a 3-cycle output stall
        operar(8'h01, 8'h01, 1'b0, 1'b0);
        ciclo();
        operar(8'h02, 8'h02, 1'b0, 1'b0);
        ciclo();
        operar(8'h03, 8'h03, 1'b0, 1'b0);
        ListoSalida = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            verificar("stall_listo_entrada", ListoEntrada, 0);
            verificar("stall_valid", ValidSalida, 1);
            verificar("stall_res", Resultado, 8'h02);
            ciclo();
        end
        ListoSalida = 1'b1;
        ciclo();
        ValidEntrada = 1'b0;
        verificar("stream_2", Resultado, 8'h04);
        verificar("stream_2_valid", ValidSalida, 1);
        ciclo();
        verificar("stream_3", Resultado, 8'h06);
        verificar("stream_3_valid", ValidSalida, 1);
        ciclo();
        verificar("stream_fin_valid", ValidSalida, 0);

        // Reset with two operations in flight
        operar(8'h10, 8'h20, 1'b0, 1'b0);
        ciclo();
        operar(8'h30, 8'h40, 1'b0, 1'b0);
        ciclo();
        ValidEntrada = 1'b0;
        ListoSalida  = 1'b0;
        rst          = 1'b1;
        ciclo();
        rst = 1'b0;
        verificar("rst_vuelo_valid", ValidSalida, 0);
        verificar("rst_vuelo_listo", ListoEntrada, 1);
        ListoSalida = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ciclo();
            verificar("rst_vuelo_sin_salida", ValidSalida, 0);
        end

        // Random stream with random stalls and bubbles
        n_acept = 0;
        ciclos  = 0;
        while (n_acept < 10000 && ciclos < 60000) begin
            Operando1    = 8'($urandom_range(255));
            Operando2    = 8'($urandom_range(255));
            CarryIn      = 1'($urandom_range(1));
            Resta        = 1'($urandom_range(1));
            ValidEntrada = ($urandom_range(3) != 0);
            ListoSalida  = ($urandom_range(3) != 0);
            ciclo();
            ciclos++;
        end
        verificar("aleatorio_aceptadas", n_acept, 10000);
        ValidEntrada = 1'b0;
        ListoSalida  = 1'b1;
        for (int i = 0; i < 10 && cola.size() != 0; i++) ciclo();
        ciclo();
        verificar("drenaje_cola", cola.size(), 0);
        verificar("drenaje_valid", ValidSalida, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
